// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encoding, default frame
// width and SCLK divider, and a counter-width helper.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    TRANSFER = 2'd2,
    HOLD     = 2'd3
  } spi_state_t;

  localparam int SPI_DATA_WIDTH_DEF = 8;
  localparam int SPI_CLK_DIV_DEF    = 4;

  // Bits needed for a down-counter that reloads with n-1.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period divider: emits alternating rise/fall strobes every CLK_DIV
// clk cycles while enabled; idles reloaded with phase cleared otherwise.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_rise,
  output logic o_fall
);

  localparam int            CW     = cnt_w(CLK_DIV);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_phase;
  logic          w_tc;

  assign w_tc = i_en && (r_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= RELOAD;
      r_phase <= 1'b0;
    end else if (!i_en) begin
      r_cnt   <= RELOAD;
      r_phase <= 1'b0;
    end else if (w_tc) begin
      r_cnt   <= RELOAD;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt - CW'(1);
    end
  end

  // First strobe after enable is a rise, since SCLK idles low.
  assign o_rise = w_tc & ~r_phase;
  assign o_fall = w_tc &  r_phase;

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master, MSB first, single frame per start request.
// Optional build macro SPI_MASTER_LOOPBACK_EN: receive path samples MOSI instead of MISO.
//
// state    | meaning
// IDLE     | cs high, waiting for start
// SETUP    | cs low, SCLK low for CLK_DIV cycles before the first edge
// TRANSFER | SCLK toggling, shifting DATA_WIDTH bits each way
// HOLD     | cs low for CLK_DIV cycles after the last falling edge
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_DATA_WIDTH_DEF,
  parameter int CLK_DIV    = SPI_CLK_DIV_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  MISO,
  output logic                  SCLK,
  output logic                  MOSI,
  output logic                  cs,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data
);

  localparam int            BW        = $clog2(DATA_WIDTH) + 1;
  localparam logic [BW-1:0] BITS_LAST = BW'(DATA_WIDTH);
  localparam int            TW        = cnt_w(CLK_DIV);
  localparam logic [TW-1:0] TMR_LOAD  = TW'(CLK_DIV - 1);

  spi_state_t            r_state;
  spi_state_t            w_state_nxt;
  logic                  w_done_nxt;
  logic [TW-1:0]         r_tmr;
  logic [BW-1:0]         r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_tx_shift;
  logic [DATA_WIDTH-1:0] r_rx_shift;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_sclk;
  logic                  r_cs;
  logic                  r_done;
  logic                  w_rise;
  logic                  w_fall;
  logic                  w_rx_bit;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk    (clk),
    .rst    (rst),
    .i_en   (r_state == TRANSFER),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

`ifdef SPI_MASTER_LOOPBACK_EN
  assign w_rx_bit = r_tx_shift[DATA_WIDTH-1];
`else
  assign w_rx_bit = MISO;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE:     if (start) w_state_nxt = SETUP;
      SETUP:    if (r_tmr == '0) w_state_nxt = TRANSFER;
      TRANSFER: if (w_fall && (r_bit_cnt == BITS_LAST)) w_state_nxt = HOLD;
      HOLD: begin
        if (r_tmr == '0) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmr      <= '0;
      r_bit_cnt  <= '0;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_sclk     <= 1'b0;
      r_cs       <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_cs   <= (w_state_nxt == IDLE);
      r_done <= w_done_nxt;

      // Timer reloads on every state change so SETUP and HOLD each last CLK_DIV cycles.
      if (w_state_nxt != r_state) r_tmr <= TMR_LOAD;
      else if (r_tmr != '0)       r_tmr <= r_tmr - TW'(1);

      if ((r_state == IDLE) && start) begin
        r_tx_shift <= tx_data;
        r_rx_shift <= '0;
        r_bit_cnt  <= '0;
      end

      if (w_rise) begin
        r_sclk     <= 1'b1;
        r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], w_rx_bit};
        r_bit_cnt  <= r_bit_cnt + BW'(1);
      end

      if (w_fall) begin
        r_sclk <= 1'b0;
        if (r_bit_cnt != BITS_LAST)
          r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
      end

      if (w_done_nxt) begin
        r_rx_data  <= r_rx_shift;
        r_tx_shift <= '0;
      end
    end
  end

  assign SCLK    = r_sclk;
  assign MOSI    = r_tx_shift[DATA_WIDTH-1];
  assign cs      = r_cs;
  assign busy    = (r_state != IDLE);
  assign done    = r_done;
  assign rx_data = r_rx_data;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master (DATA_WIDTH=8, CLK_DIV=4) with a behavioural
// mode-0 slave; define SPI_MASTER_LOOPBACK_EN to check the loopback build.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] tx_data;
  logic       MISO;
  logic       SCLK;
  logic       MOSI;
  logic       cs;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;

  int total = 0;
  int bad   = 0;

  logic [7:0] slv_load;
  logic [7:0] slv_sh  = 8'h00;
  logic [7:0] slv_rx  = 8'h00;
  int         n_rise  = 0;

  always #5 clk = ~clk;

  spi_master #(.DATA_WIDTH(8), .CLK_DIV(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .tx_data (tx_data),
    .MISO    (MISO),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .cs      (cs),
    .busy    (busy),
    .done    (done),
    .rx_data (rx_data)
  );

  // Mode-0 slave: first bit valid at cs fall, sample on rise, shift on fall.
  always @(negedge cs) slv_sh = slv_load;
  always @(posedge SCLK) begin
    if (cs === 1'b0) begin
      slv_rx = {slv_rx[6:0], MOSI};
      n_rise++;
    end
  end
  always @(negedge SCLK) if (cs === 1'b0) slv_sh = {slv_sh[6:0], 1'b0};

`ifdef SPI_MASTER_LOOPBACK_EN
  assign MISO = 1'b0;
`else
  assign MISO = slv_sh[7];
`endif

  function automatic logic [7:0] exp_rx(input logic [7:0] tx, input logic [7:0] stx);
`ifdef SPI_MASTER_LOOPBACK_EN
    return tx;
`else
    return stx;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a posedge; returns at the cycle where done is seen
  // (lat = cycles after the start cycle) or lat=-1 if the budget runs out.
  task automatic frame(input logic [7:0] tx, input logic [7:0] stx, input int mid,
                       output int lat, output int rises);
    int cyc;
    int r0;
    slv_load = stx;
    tx_data  = tx;
    start    = 1'b1;
    r0       = n_rise;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 1;
    lat   = -1;
    while (cyc <= 200 && lat < 0) begin
      if (done === 1'b1) begin
        lat = cyc;
      end else begin
        if (cyc == mid) begin
          start   = 1'b1;
          tx_data = 8'hFF;
        end
        @(posedge clk); #1;
        start = 1'b0;
        cyc++;
      end
    end
    rises = n_rise - r0;
  endtask

  initial begin
    int lat;
    int rises;
    int seen_done;
    int guard;

    rst     = 1'b1;
    start   = 1'b0;
    tx_data = 8'h00;
    slv_load = 8'h00;
    #12;
    chk("rst_cs",    cs,      1);
    chk("rst_sclk",  SCLK,    0);
    chk("rst_mosi",  MOSI,    0);
    chk("rst_busy",  busy,    0);
    chk("rst_done",  done,    0);
    chk("rst_rx",    rx_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Basic frame with latency and edge count.
    frame(8'hA5, 8'h3C, 0, lat, rises);
    chk("f1_latency", lat, 73);
    chk("f1_rises",   rises, 8);
    chk("f1_rx",      rx_data, exp_rx(8'hA5, 8'h3C));
    chk("f1_slv_rx",  slv_rx, 8'hA5);
    chk("f1_cs_at_done", cs, 1);
    @(posedge clk); #1;
    chk("f1_done_width", done, 0);

    // Start pulsed mid-frame must be ignored.
    frame(8'h96, 8'h69, 30, lat, rises);
    chk("f2_latency", lat, 73);
    chk("f2_rx",      rx_data, exp_rx(8'h96, 8'h69));
    chk("f2_slv_rx",  slv_rx, 8'h96);
    seen_done = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || cs !== 1'b1 || done !== 1'b0) seen_done++;
    end
    chk("f2_no_second_frame", seen_done, 0);
    chk("f2_rx_holds", rx_data, exp_rx(8'h96, 8'h69));

    // Reset after three SCLK rises aborts the frame.
    slv_load = 8'hE1;
    tx_data  = 8'h33;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rises = n_rise;
    guard = 0;
    while (n_rise - rises < 3 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("abort_reach_3_rises", n_rise - rises, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_cs",   cs,   1);
    chk("abort_sclk", SCLK, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rx",   rx_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0) seen_done++;
    end
    chk("abort_no_done", seen_done, 0);
    frame(8'h5A, 8'hC7, 0, lat, rises);
    chk("f3_latency", lat, 73);
    chk("f3_rises",   rises, 8);
    chk("f3_rx",      rx_data, exp_rx(8'h5A, 8'hC7));
    chk("f3_slv_rx",  slv_rx, 8'h5A);

    // Back-to-back frames, start in the cycle after done.
    frame(8'h01, 8'h81, 0, lat, rises);
    chk("b2b1_latency", lat, 73);
    chk("b2b1_rx",      rx_data, exp_rx(8'h01, 8'h81));
    chk("b2b1_slv_rx",  slv_rx, 8'h01);
    chk("b2b1_cs_high", cs, 1);
    @(posedge clk); #1;
    chk("b2b_gap_cs_high", cs, 1);
    frame(8'h80, 8'h7E, 0, lat, rises);
    chk("b2b2_latency", lat, 73);
    chk("b2b2_rises",   rises, 8);
    chk("b2b2_rx",      rx_data, exp_rx(8'h80, 8'h7E));
    chk("b2b2_slv_rx",  slv_rx, 8'h80);

    // Loopback frame: in the loopback build rx must equal tx with MISO at 0.
    @(posedge clk); #1;
    frame(8'hC3, 8'h18, 0, lat, rises);
    chk("f6_latency", lat, 73);
    chk("f6_rx",      rx_data, exp_rx(8'hC3, 8'h18));
    chk("f6_slv_rx",  slv_rx, 8'hC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
